// File: rtl/mem_narrow_port_arb_if.sv
// mem_narrow_port_arb_if: one requester channel of the narrow-port arbiter
//   req/wr/be/adr/len/wdata : request fields, stable while req high and gnt low
//   gnt    : one-cycle grant pulse, fields latched that cycle
//   wnext  : wdata consumed this cycle
//   rvalid : shared read data is valid for this requester
interface mem_narrow_port_arb_if #(parameter int LEN_W = 4);
    logic             req;
    logic             wr;
    logic [1:0]       be;
    logic [9:0]       adr;
    logic [LEN_W-1:0] len;
    logic [15:0]      wdata;
    logic             gnt;
    logic             wnext;
    logic             rvalid;
    modport master (output req, wr, be, adr, len, wdata, input gnt, wnext, rvalid);
    modport slave  (input req, wr, be, adr, len, wdata, output gnt, wnext, rvalid);
endinterface

// File: rtl/mem_narrow_port_arb.sv
// mem_narrow_port_arb: round-robin two-requester burst sequencer for the 16-bit memory port
//   clk, rst_n        : clock and synchronous active-low reset
//   p0, p1            : requester channels (request fields in, gnt/wnext/rvalid out)
//   o_rdata           : read data shared by both requesters, qualified by rvalid
//   o_busy            : burst in progress
//   o_mem_en/wen/adr/wdata, i_mem_rdata : memory narrow port, 1-cycle registered read
module mem_narrow_port_arb #(
    parameter int LEN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mem_narrow_port_arb_if.slave p0,
    mem_narrow_port_arb_if.slave p1,
    output logic [15:0]          o_rdata,
    output logic                 o_busy,
    output logic                 o_mem_en,
    output logic [1:0]           o_mem_wen,
    output logic [9:0]           o_mem_adr,
    output logic [15:0]          o_mem_wdata,
    input  logic [15:0]          i_mem_rdata
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t           state, state_nx;
    logic             last, owner, wr_q, rv_q, rv_own_q, g0, g1;
    logic [1:0]       be_q;
    logic [9:0]       adr_q;
    logic [LEN_W-1:0] len_q, cnt_q;
    // grant goes to the requester that was not served last when both ask
    assign g0 = rst_n & (state == IDLE) & p0.req & (~p1.req | last);
    assign g1 = rst_n & (state == IDLE) & p1.req & (~p0.req | ~last);
    assign p0.gnt = g0;
    assign p1.gnt = g1;
    assign p0.rvalid = rv_q & ~rv_own_q;
    assign p1.rvalid = rv_q & rv_own_q;
    assign o_rdata = i_mem_rdata;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            rv_q     <= 1'b0;
            rv_own_q <= 1'b0;
            owner    <= 1'b0;
            wr_q     <= 1'b0;
            be_q     <= 2'b00;
            adr_q    <= 10'd0;
            len_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state    <= state_nx;
            rv_q     <= (state == BURST) & ~wr_q;
            rv_own_q <= owner;
            if (g0 | g1) begin
                owner <= g1;
                last  <= g1;
                wr_q  <= g1 ? p1.wr : p0.wr;
                be_q  <= g1 ? p1.be : p0.be;
                adr_q <= g1 ? p1.adr : p0.adr;
                len_q <= g1 ? p1.len : p0.len;
                cnt_q <= '0;
            end else if (state == BURST) begin
                adr_q <= adr_q + 10'd1;
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end
    end
    always_comb begin
        state_nx    = state;
        p0.wnext    = 1'b0;
        p1.wnext    = 1'b0;
        o_busy      = 1'b0;
        o_mem_en    = 1'b0;
        o_mem_wen   = 2'b00;
        o_mem_adr   = 10'd0;
        o_mem_wdata = 16'h0;
        if (state == IDLE) begin
            state_nx = (g0 | g1) ? BURST : IDLE;
        end else begin
            state_nx    = (cnt_q == len_q) ? IDLE : BURST;
            o_busy      = 1'b1;
            o_mem_en    = 1'b1;
            o_mem_adr   = adr_q;
            o_mem_wen   = wr_q ? be_q : 2'b00;
            o_mem_wdata = wr_q ? (owner ? p1.wdata : p0.wdata) : 16'h0;
            p0.wnext    = wr_q & ~owner;
            p1.wnext    = wr_q & owner;
        end
    end
endmodule

// File: tb/tb_mem_narrow_port_arb.sv
// tb_mem_narrow_port_arb: cycle-table check of the narrow-port arbiter against a memory model
module tb_mem_narrow_port_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] o_rdata, o_mem_wdata, i_mem_rdata;
    logic        o_busy, o_mem_en;
    logic [1:0]  o_mem_wen;
    logic [9:0]  o_mem_adr;
    logic [15:0] mem [1024];
    int          nvec = 0;
    int          nerr = 0;

    mem_narrow_port_arb_if #(.LEN_W(4)) if0 ();
    mem_narrow_port_arb_if #(.LEN_W(4)) if1 ();

    mem_narrow_port_arb #(.LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .p0(if0.slave), .p1(if1.slave),
        .o_rdata(o_rdata), .o_busy(o_busy), .o_mem_en(o_mem_en), .o_mem_wen(o_mem_wen),
        .o_mem_adr(o_mem_adr), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        mem[5] = 16'hA5A5;
    end

    always @(posedge clk) begin
        if (o_mem_en) begin
            if (o_mem_wen[0]) mem[o_mem_adr][7:0] <= o_mem_wdata[7:0];
            if (o_mem_wen[1]) mem[o_mem_adr][15:8] <= o_mem_wdata[15:8];
            i_mem_rdata <= mem[o_mem_adr];
        end
    end

    typedef struct packed {
        logic        rst;
        logic [1:0]  req;
        logic        wr;
        logic [1:0]  be;
        logic [9:0]  adr;
        logic [3:0]  len;
        logic [15:0] wd;
        logic        full;
        logic [1:0]  gnt;
        logic [1:0]  wn;
        logic [1:0]  rv;
        logic        busy;
        logic        en;
        logic [1:0]  wen;
        logic [9:0]  madr;
        logic [15:0] mwd;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl[$];

    task automatic check_mem(input int a, input logic [15:0] e, input string nm);
        nvec++;
        if (mem[a] !== e) begin
            nerr++;
            $display("FAIL %s: mem[%0d]=%h expected %h", nm, a, mem[a], e);
        end
    endtask

    initial begin
        // reset
        tbl.push_back('{'0, 2'b00, '0, 2'b00, 10'd0, 4'd0, 16'h0, '1,  2'b00, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'0, 2'b00, '0, 2'b00, 10'd0, 4'd0, 16'h0, '1,  2'b00, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        // single read at 5
        tbl.push_back('{'1, 2'b01, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b01, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd5, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b01, '0, '0, 2'b00, 10'd0, 16'h0, 16'hA5A5});
        // write burst wrapping 1022..1
        tbl.push_back('{'1, 2'b10, '1, 2'b11, 10'd1022, 4'd3, 16'h1111, '0,  2'b10, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '1, 2'b11, 10'd1022, 4'd3, 16'h1111, '0,  2'b00, 2'b10, 2'b00, '1, '1, 2'b11, 10'd1022, 16'h1111, 16'h0});
        tbl.push_back('{'1, 2'b00, '1, 2'b11, 10'd1022, 4'd3, 16'h2222, '0,  2'b00, 2'b10, 2'b00, '1, '1, 2'b11, 10'd1023, 16'h2222, 16'h0});
        tbl.push_back('{'1, 2'b00, '1, 2'b11, 10'd1022, 4'd3, 16'h3333, '0,  2'b00, 2'b10, 2'b00, '1, '1, 2'b11, 10'd0, 16'h3333, 16'h0});
        tbl.push_back('{'1, 2'b00, '1, 2'b11, 10'd1022, 4'd3, 16'h4444, '0,  2'b00, 2'b10, 2'b00, '1, '1, 2'b11, 10'd1, 16'h4444, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd0, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        // readback of the wrapped burst
        tbl.push_back('{'1, 2'b10, '0, 2'b11, 10'd1022, 4'd3, 16'h0, '0,  2'b10, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b11, 10'd1022, 4'd3, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd1022, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b11, 10'd1022, 4'd3, 16'h0, '0,  2'b00, 2'b00, 2'b10, '1, '1, 2'b00, 10'd1023, 16'h0, 16'h1111});
        tbl.push_back('{'1, 2'b00, '0, 2'b11, 10'd1022, 4'd3, 16'h0, '0,  2'b00, 2'b00, 2'b10, '1, '1, 2'b00, 10'd0, 16'h0, 16'h2222});
        tbl.push_back('{'1, 2'b00, '0, 2'b11, 10'd1022, 4'd3, 16'h0, '0,  2'b00, 2'b00, 2'b10, '1, '1, 2'b00, 10'd1, 16'h0, 16'h3333});
        tbl.push_back('{'1, 2'b00, '0, 2'b11, 10'd1022, 4'd3, 16'h0, '0,  2'b00, 2'b00, 2'b10, '0, '0, 2'b00, 10'd0, 16'h0, 16'h4444});
        // upper-byte write of BEEF at 7, then read back
        tbl.push_back('{'1, 2'b01, '1, 2'b10, 10'd7, 4'd0, 16'hBEEF, '0,  2'b01, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '1, 2'b10, 10'd7, 4'd0, 16'hBEEF, '0,  2'b00, 2'b01, 2'b00, '1, '1, 2'b10, 10'd7, 16'hBEEF, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd0, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b01, '0, 2'b00, 10'd7, 4'd0, 16'h0, '0,  2'b01, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd7, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd7, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd7, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b01, '0, '0, 2'b00, 10'd0, 16'h0, 16'hBE00});
        // be=00 write over 5..6 still takes two beats
        tbl.push_back('{'1, 2'b10, '1, 2'b00, 10'd5, 4'd1, 16'hFFFF, '0,  2'b10, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '1, 2'b00, 10'd5, 4'd1, 16'hFFFF, '0,  2'b00, 2'b10, 2'b00, '1, '1, 2'b00, 10'd5, 16'hFFFF, 16'h0});
        tbl.push_back('{'1, 2'b00, '1, 2'b00, 10'd5, 4'd1, 16'hFFFF, '0,  2'b00, 2'b10, 2'b00, '1, '1, 2'b00, 10'd6, 16'hFFFF, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd0, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b01, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b01, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd5, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b01, '0, '0, 2'b00, 10'd0, 16'h0, 16'hA5A5});
        // len=15 read from 16, reset at beat 4
        tbl.push_back('{'1, 2'b01, '0, 2'b00, 10'd16, 4'd15, 16'h0, '0,  2'b01, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd16, 4'd15, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd16, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd16, 4'd15, 16'h0, '0,  2'b00, 2'b00, 2'b01, '1, '1, 2'b00, 10'd17, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd16, 4'd15, 16'h0, '0,  2'b00, 2'b00, 2'b01, '1, '1, 2'b00, 10'd18, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd16, 4'd15, 16'h0, '0,  2'b00, 2'b00, 2'b01, '1, '1, 2'b00, 10'd19, 16'h0, 16'h0});
        tbl.push_back('{'0, 2'b00, '0, 2'b00, 10'd16, 4'd15, 16'h0, '0,  2'b00, 2'b00, 2'b01, '1, '1, 2'b00, 10'd20, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd16, 4'd15, 16'h0, '1,  2'b00, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        // round robin, both held, len=1 reads at 1022
        tbl.push_back('{'1, 2'b11, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b01, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b11, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd1022, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b11, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b00, 2'b00, 2'b01, '1, '1, 2'b00, 10'd1023, 16'h0, 16'h1111});
        tbl.push_back('{'1, 2'b11, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b10, 2'b00, 2'b01, '0, '0, 2'b00, 10'd0, 16'h0, 16'h2222});
        tbl.push_back('{'1, 2'b11, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd1022, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b11, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b00, 2'b00, 2'b10, '1, '1, 2'b00, 10'd1023, 16'h0, 16'h1111});
        tbl.push_back('{'1, 2'b11, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b01, 2'b00, 2'b10, '0, '0, 2'b00, 10'd0, 16'h0, 16'h2222});
        tbl.push_back('{'1, 2'b11, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd1022, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b11, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b00, 2'b00, 2'b01, '1, '1, 2'b00, 10'd1023, 16'h0, 16'h1111});
        tbl.push_back('{'1, 2'b11, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b10, 2'b00, 2'b01, '0, '0, 2'b00, 10'd0, 16'h0, 16'h2222});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd1022, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b00, 2'b00, 2'b10, '1, '1, 2'b00, 10'd1023, 16'h0, 16'h1111});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd1022, 4'd1, 16'h0, '0,  2'b00, 2'b00, 2'b10, '0, '0, 2'b00, 10'd0, 16'h0, 16'h2222});
        // back-to-back single reads by requester 0
        tbl.push_back('{'1, 2'b01, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b01, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b01, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd5, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b01, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b01, 2'b00, 2'b01, '0, '0, 2'b00, 10'd0, 16'h0, 16'hA5A5});
        tbl.push_back('{'1, 2'b01, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd5, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b01, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b01, 2'b00, 2'b01, '0, '0, 2'b00, 10'd0, 16'h0, 16'hA5A5});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b00, '1, '1, 2'b00, 10'd5, 16'h0, 16'h0});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd5, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b01, '0, '0, 2'b00, 10'd0, 16'h0, 16'hA5A5});
        tbl.push_back('{'1, 2'b00, '0, 2'b00, 10'd0, 4'd0, 16'h0, '0,  2'b00, 2'b00, 2'b00, '0, '0, 2'b00, 10'd0, 16'h0, 16'h0});

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t v;
            logic ok;
            v = tbl[i];
            @(negedge clk);
            rst_n = v.rst;
            if0.req = v.req[0]; if0.wr = v.wr; if0.be = v.be; if0.adr = v.adr; if0.len = v.len; if0.wdata = v.wd;
            if1.req = v.req[1]; if1.wr = v.wr; if1.be = v.be; if1.adr = v.adr; if1.len = v.len; if1.wdata = v.wd;
            #1;
            ok = ({if1.gnt, if0.gnt} === v.gnt) && ({if1.wnext, if0.wnext} === v.wn) &&
                 ({if1.rvalid, if0.rvalid} === v.rv) && (o_busy === v.busy) &&
                 (o_mem_en === v.en) && (o_mem_wen === v.wen) &&
                 (!(v.en || v.full) || o_mem_adr === v.madr) &&
                 (!((v.wn != 2'b00) || v.full) || o_mem_wdata === v.mwd) &&
                 ((v.rv == 2'b00) || o_rdata === v.rd);
            nvec++;
            if (!ok) begin
                nerr++;
                $display("FAIL row %0d: got gnt=%b wn=%b rv=%b busy=%b en=%b wen=%b adr=%0d wd=%h rd=%h; want gnt=%b wn=%b rv=%b busy=%b en=%b wen=%b adr=%0d wd=%h rd=%h",
                         i, {if1.gnt, if0.gnt}, {if1.wnext, if0.wnext}, {if1.rvalid, if0.rvalid}, o_busy, o_mem_en,
                         o_mem_wen, o_mem_adr, o_mem_wdata, o_rdata, v.gnt, v.wn, v.rv, v.busy, v.en, v.wen, v.madr, v.mwd, v.rd);
            end
        end

        // requests held during reset are never granted
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            if0.req = 1'b1;
            if1.req = 1'b1;
            #1;
            nvec++;
            if ({if1.gnt, if0.gnt, o_busy, o_mem_en} !== 4'b0000) begin
                nerr++;
                $display("FAIL rst_hold %0d: gnt=%b busy=%b en=%b want 00 0 0", i, {if1.gnt, if0.gnt}, o_busy, o_mem_en);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        if0.req = 1'b0;
        if1.req = 1'b0;

        check_mem(1023, 16'h2222, "wrap_1023");
        check_mem(0, 16'h3333, "wrap_0");
        check_mem(7, 16'hBE00, "be10_7");
        check_mem(5, 16'hA5A5, "be00_5");
        check_mem(6, 16'h0000, "be00_6");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_narrow_port_arb.md
# mem_narrow_port_arb

Two-requester, round-robin arbiter and burst sequencer for the 16-bit narrow port of the 1024x16 / 512x32 dual-port memory. It grants one requester at a time and issues single or burst accesses of 1 to 2^LEN_W halfwords with auto-incrementing, wrapping addresses. Read data returns with a per-requester valid strobe. It sits between the local consumers (e.g. DMA engine and CPU-side bridge) and the memory's narrow port. The wide port is untouched.

## Interface
- LEN_W, 4, width of burst length field; burst = i_lenX + 1 halfwords (1..16 at default)
- clk  in  1  single clock, also drives memory narrow port clock
- rst_n  in  1  synchronous, active-low reset
- i_req0 / i_req1  in  1  request; fields below must stay stable while req high and gnt low
- i_wr0 / i_wr1  in  1  1 = write burst, 0 = read burst
- i_be0 / i_be1  in  2  byte enables applied to every write beat ([1] = bits 15:8)
- i_adr0 / i_adr1  in  10  start halfword address
- i_len0 / i_len1  in  LEN_W  burst length minus one
- i_wdata0 / i_wdata1  in  16  write data for current beat
- o_gnt0 / o_gnt1  out  1  one-cycle grant pulse; request fields latched this cycle
- o_wnext0 / o_wnext1  out  1  current i_wdataX consumed this cycle; present next beat on following cycle
- o_rvalid0 / o_rvalid1  out  1  o_rdata valid for this requester
- o_rdata  out  16  read data (shared; qualified by o_rvalidX)
- o_busy  out  1  burst in progress
- o_mem_en  out  1  memory narrow-port enable
- o_mem_wen  out  2  memory narrow-port byte write enables
- o_mem_adr  out  10  memory narrow-port address
- o_mem_wdata  out  16  memory narrow-port write data
- i_mem_rdata  in  16  memory narrow-port read data (1-cycle registered read)

## Operation
- States: IDLE, BURST.
- IDLE: o_mem_en = 0. If any i_reqX is high, grant one, pulse o_gntX, and latch owner, wr, be, adr, len. Beat counter is cleared. Go to BURST.
- Arbitration: round-robin pointer `last`. On simultaneous requests, the requester != last wins. After every grant, `last` = granted index. Reset value of `last` is 1, so requester 0 wins the first tie.
- Requests are sampled only in IDLE. A req still high in IDLE after a completed burst is a new request. Requesters deassert req the cycle after gnt unless they want a back-to-back burst. A req dropped before gnt is simply withdrawn.
- BURST, every cycle:
  - o_mem_en = 1, o_mem_adr = current address.
  - Write: o_mem_wen = latched be and o_mem_wdata = i_wdata of owner (combinational pass-through). o_wnextOwner = 1.
  - Read: o_mem_wen = 0 and o_wnext = 0.
  - The address increments mod 1024 (1023 -> 0) and the counter increments.
- Last beat: counter == len. Next state is IDLE.
- A write with be = 2'b00 still runs all beats with o_mem_wen = 0. This is legal and wastes the slot.
- Read return: o_rvalidOwner = 1 one cycle after each read beat; o_rdata = i_mem_rdata. A read-valid pipeline register (owner, valid) ensures the final beat's data returns even though state is already IDLE.
- Reset (rst_n low at a clock edge), including mid-burst:
  - state -> IDLE, last -> 1, and the pending read-valid pipeline is cleared.
  - All outputs are 0 the cycle after: o_gntX, o_wnextX, o_rvalidX, o_busy, o_mem_en, o_mem_wen, o_mem_adr, o_mem_wdata.
  - o_rdata follows i_mem_rdata and is don't-care without valid.
  - An aborted burst is not resumed.

## Timing
- Grant at cycle T (IDLE). Beats at T+1 .. T+1+len. o_busy high over the same cycles.
- Read data valid at T+2 .. T+2+len, one per cycle with no gaps.
- State is IDLE at T+2+len. The earliest next grant is that cycle and its first beat is at T+3+len. One idle cycle separates bursts, so the maximum duty is (len+1)/(len+2).
- Write: the beat at cycle k uses i_wdata sampled combinationally in cycle k. o_wnext marks the same cycle.
- o_gnt and o_wnext are combinational from registered state plus the inputs of the current cycle. o_rvalid is registered.

## Test plan
- Single read: req0 with adr=5, len=0, wr=0; memory preloaded with 0xA5A5 at address 5. Required: gnt0 at T, o_mem_en and adr=5 at T+1, o_rvalid0 with o_rdata=0xA5A5 at T+2, o_busy low at T+2.
- Write burst with wrap: req1 with adr=1022, len=3, be=2'b11, data 0x1111..0x4444. Required: o_mem_adr 1022, 1023, 0, 1 on four consecutive cycles, four o_wnext1 pulses, and a readback returning the same data.
- Byte enables: write be=2'b10 of 0xBEEF over 0x0000 at adr 7, then read adr 7. Required: 0xBE00. A write with be=2'b00 leaves memory unchanged and still takes len+1 cycles.
- Round-robin: req0 and req1 both held high with len=1. Required: grants alternate 0, 1, 0, 1 starting with 0 after reset, with one idle cycle between each 2-beat burst.
- Reset mid-burst: start a len=15 read, assert rst_n low at beat 4. Required: all outputs 0 the cycle after, no o_rvalid afterwards, and the next simultaneous request is granted to requester 0.
- Back-to-back same requester: req0 held high with len=0. Required: a grant every 2 cycles, with o_rvalid0 pulses 2 cycles apart.
